// File: rtl/deform_frac_integ.sv
// deform_frac_integ: deformable fractional-order integrator.
//   y[n] = y[n-1]*DECAY + x[n]*GAIN   (signed Q8.24)
// A single 32x32 signed multiplier is time-shared between the feedback
// and the input product, sequenced by IDLE -> MUL_Y -> MUL_X -> SUM -> OUT.
// Optional feature: define DEFORM_INTEG_SAT_EN to saturate the sum and
// raise a sticky sat_flag; otherwise the sum wraps and sat_flag is 0.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. in_ready is high only in IDLE. out_valid stays high and
// out_data stays stable until the edge where out_ready is also high.
module deform_frac_integ #(
    parameter logic signed [31:0] DECAY = 32'sd16610280,
    parameter logic signed [31:0] GAIN  = 32'sd335544,
    parameter int                 FRAC  = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_toggle,
    output logic        sat_flag,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MUL_Y = 3'd1,
        MUL_X = 3'd2,
        SUM   = 3'd3,
        OUT   = 3'd4
    } state_t;

    state_t state;
    state_t state_next;

    logic signed [31:0] y_reg;
    logic signed [31:0] x_reg;
    logic signed [31:0] mul_a;
    logic signed [31:0] mul_b;
    logic signed [63:0] prod;
    logic        [31:0] p_y_hi;
    logic        [31:0] p_x_hi;
    logic        [32:0] s;
    logic        [31:0] result;

    // Bits of the product below the binary point and above the Q8.24 range are dropped.
    logic unused_prod_bits;
    assign unused_prod_bits = ^{prod[63:FRAC+32], prod[FRAC-1:0]};

    assign in_ready  = (state == IDLE);
    assign state_dbg = state;

    // Shared multiplier: feedback product in MUL_Y, input product otherwise.
    assign mul_a = (state == MUL_Y) ? y_reg : x_reg;
    assign mul_b = (state == MUL_Y) ? DECAY : GAIN;
    assign prod  = 64'(mul_a) * 64'(mul_b);

    // The Q8.24 slices are sign-extended to 33 bits so overflow is visible in s[32:31].
    assign s = {p_y_hi[31], p_y_hi} + {p_x_hi[31], p_x_hi};

`ifdef DEFORM_INTEG_SAT_EN
    logic sat_hit;

    // Clamp the 33-bit sum into the signed 32-bit range.
    always_comb begin
        result  = s[31:0];
        sat_hit = 1'b0;
        if (s[32:31] == 2'b01) begin
            result  = 32'h7FFF_FFFF;
            sat_hit = 1'b1;
        end else if (s[32:31] == 2'b10) begin
            result  = 32'h8000_0000;
            sat_hit = 1'b1;
        end
    end

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_flag <= 1'b0;
        end else if (state == SUM && sat_hit) begin
            sat_flag <= 1'b1;
        end
    end
`else
    logic unused_sum_sign;
    assign unused_sum_sign = s[32];
    assign result          = s[31:0];
    assign sat_flag        = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = MUL_Y;
            MUL_Y:   state_next = MUL_X;
            MUL_X:   state_next = SUM;
            SUM:     state_next = OUT;
            OUT:     if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath registers, advanced by the current state.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_reg      <= '0;
            x_reg      <= '0;
            p_y_hi     <= '0;
            p_x_hi     <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_toggle <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) x_reg <= in_data;
                end
                MUL_Y: p_y_hi <= prod[FRAC+31:FRAC];
                MUL_X: p_x_hi <= prod[FRAC+31:FRAC];
                SUM: begin
                    y_reg     <= result;
                    out_data  <= result;
                    out_valid <= 1'b1;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid  <= 1'b0;
                        out_toggle <= ~out_toggle;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_deform_frac_integ.sv
// tb_deform_frac_integ: directed bench for deform_frac_integ.
// Instance a uses the default coefficients; instance b uses DECAY=GAIN=1.0
// to drive the sum into overflow. Both share every input and run in lockstep.
module tb_deform_frac_integ;

    logic        clk;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, a_out_toggle, a_sat_flag;
    logic [31:0] a_out_data;
    logic [2:0]  a_state;
    logic        b_in_ready, b_out_valid, b_out_toggle, b_sat_flag;
    logic [31:0] b_out_data;
    logic [2:0]  b_state;

    int n_checks;
    int n_pass;

    deform_frac_integ dut_a (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_toggle(a_out_toggle), .sat_flag(a_sat_flag), .state_dbg(a_state)
    );

    deform_frac_integ #(.DECAY(32'sd16777216), .GAIN(32'sd16777216)) dut_b (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_toggle(b_out_toggle), .sat_flag(b_sat_flag), .state_dbg(b_state)
    );

    // Clock and reset defaults.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h (%0d) expected 0x%08h (%0d)", tag, got, $signed(got), exp, $signed(exp));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Offer one sample, wait for out_valid; returns the output and the edge count after accept.
    task automatic send(input logic [31:0] x, output logic [31:0] y, output int lat);
        int n;
        n = 0;
        while (!a_in_ready && n < 20) begin
            tick();
            n++;
        end
        if (!a_in_ready) check("in_ready_timeout", {31'd0, a_in_ready}, 32'd1);
        in_data  = x;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!a_out_valid && lat < 20) begin
            tick();
            lat++;
        end
        y = a_out_data;
    endtask

    // Complete the output handshake (out_ready is already high).
    task automatic consume();
        tick();
    endtask

    initial begin
        logic [31:0] y;
        logic [31:0] b_first;
        int lat;
        logic toggle_before;

        n_checks  = 0;
        n_pass    = 0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;

        // Reset state.
        do_reset();
        check("rst_state",      {29'd0, a_state},      32'd0);
        check("rst_out_data",   a_out_data,            32'd0);
        check("rst_out_valid",  {31'd0, a_out_valid},  32'd0);
        check("rst_out_toggle", {31'd0, a_out_toggle}, 32'd0);
        check("rst_sat_flag",   {31'd0, a_sat_flag},   32'd0);
        check("rst_in_ready",   {31'd0, a_in_ready},   32'd1);

        // 1.0 from y=0: 2^24*335544 >> 24 = 335544.
        send(32'd16777216, y, lat);
        check("s1_latency", lat, 32'd3);
        check("s1_data", y, 32'd335544);
        consume();
        check("s1_toggle", {31'd0, a_out_toggle}, 32'd1);
        check("s1_valid_clr", {31'd0, a_out_valid}, 32'd0);

        // 335544*16610280 >> 24 = 332205; + 335544 = 667749.
        send(32'd16777216, y, lat);
        check("s2_data", y, 32'd667749);
        consume();
        check("s2_toggle", {31'd0, a_out_toggle}, 32'd0);

        // 667749*16610280 = 11091497859720; >> 24 = 661104 (remainder 13253256).
        send(32'd0, y, lat);
        check("s3_data", y, 32'd661104);
        consume();

        // Backpressure: output held for 6 cycles, in_valid pulses ignored.
        do_reset();
        out_ready = 1'b0;
        send(32'd16777216, y, lat);
        check("bp_data", y, 32'd335544);
        toggle_before = a_out_toggle;
        for (int i = 0; i < 6; i++) begin
            in_data  = 32'h7FFF_FFFF;
            in_valid = (i % 2 == 0);
            tick();
            check("bp_hold_data",  a_out_data,            32'd335544);
            check("bp_hold_valid", {31'd0, a_out_valid},  32'd1);
            check("bp_in_ready",   {31'd0, a_in_ready},   32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release_valid",  {31'd0, a_out_valid},  32'd0);
        check("bp_release_toggle", {31'd0, a_out_toggle}, {31'd0, ~toggle_before});
        // Only the decayed 335544 remains if the ignored pulses left no trace: 332205.
        send(32'd0, y, lat);
        check("bp_next_data", y, 32'd332205);
        consume();

        // Negative input: -2^24*335544 >> 24 = -335544 = 0xFFFAE148.
        do_reset();
        send(32'hFF00_0000, y, lat);
        check("neg_data", y, 32'hFFFA_E148);
        consume();

        // Reset while in MUL_X discards the sample and clears y_reg.
        do_reset();
        send(32'd16777216, y, lat);
        consume();
        in_data  = 32'd16777216;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("midrst_in_mulx", {29'd0, a_state}, 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_state",  {29'd0, a_state},      32'd0);
        check("midrst_valid",  {31'd0, a_out_valid},  32'd0);
        check("midrst_toggle", {31'd0, a_out_toggle}, 32'd0);
        check("midrst_ready",  {31'd0, a_in_ready},   32'd1);
        send(32'd16777216, y, lat);
        check("midrst_data", y, 32'd335544);
        consume();

        // Overflow on instance b: 0x7FFFFFFF twice with DECAY=GAIN=1.0.
        do_reset();
        send(32'h7FFF_FFFF, y, lat);
        b_first = b_out_data;
        check("sat1_valid", {31'd0, b_out_valid}, 32'd1);
        check("sat1_data", b_first, 32'h7FFF_FFFF);
        check("sat1_flag", {31'd0, b_sat_flag}, 32'd0);
        consume();
        send(32'h7FFF_FFFF, y, lat);
`ifdef DEFORM_INTEG_SAT_EN
        check("sat2_data", b_out_data, 32'h7FFF_FFFF);
        check("sat2_flag", {31'd0, b_sat_flag}, 32'd1);
`else
        check("sat2_data", b_out_data, 32'hFFFF_FFFE);
        check("sat2_flag", {31'd0, b_sat_flag}, 32'd0);
`endif
        consume();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
